seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4096, clk cycles per digit slot; SHALL be >= 2.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 frm_valid  in  1  producer offers a 4-digit frame.
REQ-005 frm_ready  out  1  block can accept a frame; transfer occurs on the edge where frm_valid && frm_ready.
REQ-006 frm_data  in  32  frame; frm_data[8*i+7:8*i] = active-low segment code for digit i (bit 7 = dp).
REQ-007 blank  in  1  suppress display output while high.
REQ-008 seg  out  12  seg[11:8] active-low digit enable (bit 8 = digit 0); seg[7:0] active-low segments.
REQ-009 frame_done  out  1  one-cycle pulse at every frame boundary.

Function
REQ-010 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be true in the cycle where count == TICK_DIV-1.
REQ-011 The digit pointer ptr (2 bits) SHALL change only on tick: 0->1->2->3->0.
REQ-012 On tick with blank low, seg SHALL load {~(4'b1 << ptr), active[ptr]} (registered; visible the cycle after tick).
REQ-013 On tick with blank high, seg SHALL load 12'hFFF; ptr advance, swap and frame_done SHALL be unaffected by blank.
REQ-014 Between ticks seg SHALL hold its value.
REQ-015 Two frame buffers: pending (pend, with flag pend_full) and active (drives display).
REQ-016 frm_ready SHALL equal !pend_full combinationally, and SHALL be 0 while rst_n is low.
REQ-017 On transfer, pend SHALL load frm_data and pend_full SHALL set.
REQ-018 Frame boundary = tick with ptr == 3; frame_done SHALL be 1 in the cycle after it, else 0.
REQ-019 At a frame boundary with pend_full set, active SHALL load pend and pend_full SHALL clear; the new frame SHALL first appear at the next tick (digit 0). No mid-frame update of active, ever.
REQ-020 At a frame boundary with pend_full clear, active SHALL hold.
REQ-021 Transfer in the same cycle as a frame boundary (pend_full was clear): frame SHALL go to pend only and be displayed from the following boundary.
REQ-022 frm_data SHALL be ignored whenever no transfer occurs; frm_valid high with frm_ready low SHALL have no effect.

Reset
REQ-023 rst_n low SHALL force: count 0, ptr 0, pend_full 0, pend 32'hFFFFFFFF, active 32'hFFFFFFFF, seg 12'hFFF, frame_done 0.
REQ-024 Reset mid-frame SHALL discard both buffers; the first tick after release SHALL occur TICK_DIV cycles after the first cycle with rst_n high and drive digit 0.

Structure
REQ-025 Package seg_pkg SHALL hold: NUM_DIGITS = 4, SEG_OFF = 8'hFF, DIG_OFF = 4'hF, digit glyph codes 0-9 and letters U,P,d,o,L,E,R,I,S.
REQ-026 Prescaler SHALL be a sub-module seg_tick (parameter TICK_DIV; ports clk, rst_n, tick).
REQ-027 All other logic (handshake, buffers, scan, output register) SHALL reside in seg_scan_ctrl; no combinational path from frm_valid or frm_data to seg.

Verification (TICK_DIV = 4)
REQ-028 Release reset, no frames -> seg 12'hFFF for 4 cycles, then 12'hEFF, 12'hDFF, 12'hBFF, 12'h7FF at 4-cycle spacing; frm_ready 1.
REQ-029 Send 32'hB0A4F9C0 while ptr = 1 -> frm_ready drops the next cycle; after the following boundary seg = 12'hEC0, 12'hDF9, 12'hBA4, 12'h7B0; frame_done pulses at each boundary; frm_ready returns 1 the cycle after swap.
REQ-030 Hold frm_valid with frames A then B back-to-back -> B stalled (frm_ready 0) until A swaps; B displayed one frame after A; no frame dropped or duplicated.
REQ-031 Transfer exactly in a boundary cycle -> old frame repeats for one full frame, new frame from next boundary.
REQ-032 Raise blank for digits 1-2 -> seg 12'hFFF in those slots, ptr sequence and frame_done timing unchanged.
REQ-033 Assert rst_n low for 1 cycle while ptr = 2 with a pending frame -> all outputs return to reset values; pending frame never displayed.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner.
// All segment codes are active-low; bit 7 is the decimal point.
package seg_pkg;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned PTR_W      = $clog2(NUM_DIGITS);
    localparam int unsigned FRAME_W    = NUM_DIGITS * 8;

    localparam logic [7:0]         SEG_OFF   = 8'hFF;
    localparam logic [3:0]         DIG_OFF   = 4'hF;
    localparam logic [FRAME_W-1:0] FRAME_OFF = {NUM_DIGITS{SEG_OFF}};

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;

    localparam logic [7:0] GLYPH_U = 8'hC1;
    localparam logic [7:0] GLYPH_P = 8'h8C;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_O = 8'hA3;
    localparam logic [7:0] GLYPH_L = 8'hC7;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_R = 8'hAF;
    localparam logic [7:0] GLYPH_I = 8'hCF;
    localparam logic [7:0] GLYPH_S = 8'h92;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        g = SEG_OFF;
        case (d)
            4'd0: g = GLYPH_0;
            4'd1: g = GLYPH_1;
            4'd2: g = GLYPH_2;
            4'd3: g = GLYPH_3;
            4'd4: g = GLYPH_4;
            4'd5: g = GLYPH_5;
            4'd6: g = GLYPH_6;
            4'd7: g = GLYPH_7;
            4'd8: g = GLYPH_8;
            4'd9: g = GLYPH_9;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction
endpackage

// File: rtl/seg_tick.sv
// Free-running prescaler: tick is high for one cycle every TICK_DIV cycles.
// Latency: first tick in the TICK_DIV-th cycle after reset release; no backpressure.
module seg_tick #(
    parameter int unsigned TICK_DIV = 4096
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned      CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered 4-digit display scanner: frames land in pend, swap to active only at frame boundaries.
// Latency: seg registered one cycle after each tick; frm_ready = !pend_full, so one frame may wait at a time.
module seg_scan_ctrl #(
    parameter int unsigned TICK_DIV = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frm_valid,
    output logic        frm_ready,
    input  logic [31:0] frm_data,
    input  logic        blank,
    output logic [11:0] seg,
    output logic        frame_done
);
    import seg_pkg::*;

    logic tick;

    seg_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [FRAME_W-1:0] pend_q, pend_d;
    logic [FRAME_W-1:0] act_q, act_d;
    logic               pend_full_q, pend_full_d;
    logic [11:0]        seg_q, seg_d;
    logic               frame_done_q, frame_done_d;
    logic               boundary;
    logic               xfer;

    assign frm_ready  = rst_n & ~pend_full_q;
    assign xfer       = frm_valid & frm_ready;
    assign boundary   = tick && (ptr_q == PTR_W'(NUM_DIGITS - 1));
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

    always_comb begin
        ptr_d        = ptr_q;
        pend_d       = pend_q;
        act_d        = act_q;
        pend_full_d  = pend_full_q;
        seg_d        = seg_q;
        frame_done_d = boundary;

        if (tick) begin
            ptr_d = ptr_q + 1'b1;
            if (blank) begin
                seg_d = {DIG_OFF, SEG_OFF};
            end else begin
                seg_d = {~(4'b0001 << ptr_q), act_q[{ptr_q, 3'b000} +: 8]};
            end
        end

        // Swap only when the last digit has just been latched, so a frame is never torn.
        if (boundary && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end

        // xfer implies pend was empty, so it cannot collide with the swap above.
        if (xfer) begin
            pend_d      = frm_data;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            pend_q       <= FRAME_OFF;
            act_q        <= FRAME_OFF;
            pend_full_q  <= 1'b0;
            seg_q        <= {DIG_OFF, SEG_OFF};
            frame_done_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            act_q        <= act_d;
            pend_full_q  <= pend_full_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with TICK_DIV = 4: directed scenarios then random traffic,
// every cycle compared against a cycle-count based reference model.
module tb_seg_scan_ctrl;
    localparam int TD = 4;

    logic        clk;
    logic        rst_n;
    logic        frm_valid;
    logic        frm_ready;
    logic [31:0] frm_data;
    logic        blank;
    logic [11:0] seg;
    logic        frame_done;

    seg_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_data   (frm_data),
        .blank      (blank),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: display timing derived purely from cycles since reset release.
    int          m_cyc  = 0;
    logic        m_full = 1'b0;
    logic [31:0] m_pend = 32'hFFFF_FFFF;
    logic [31:0] m_act  = 32'hFFFF_FFFF;
    logic [11:0] m_seg  = 12'hFFF;
    logic        m_fd   = 1'b0;
    logic        m_xfer = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [31:0] d, input logic b);
        int          slot;
        logic        tk;
        logic [3:0]  en;
        logic [31:0] sh;
        m_xfer = r && v && !m_full;
        if (!r) begin
            m_cyc  = 0;
            m_full = 1'b0;
            m_pend = 32'hFFFF_FFFF;
            m_act  = 32'hFFFF_FFFF;
            m_seg  = 12'hFFF;
            m_fd   = 1'b0;
        end else begin
            slot = (m_cyc / TD) % 4;
            tk   = (m_cyc % TD) == (TD - 1);
            m_fd = tk && (slot == 3);
            if (tk) begin
                for (int i = 0; i < 4; i++) en[i] = (i != slot);
                sh    = m_act >> (8 * slot);
                m_seg = b ? 12'hFFF : {en, sh[7:0]};
            end
            if (m_fd && m_full) begin
                m_act  = m_pend;
                m_full = 1'b0;
            end
            if (m_xfer) begin
                m_pend = d;
                m_full = 1'b1;
            end
            m_cyc++;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d, input logic b);
        rst_n     = r;
        frm_valid = v;
        frm_data  = d;
        blank     = b;
        #1;
        chk("frm_ready", {31'd0, frm_ready}, {31'd0, r && !m_full});
        @(posedge clk);
        model_edge(r, v, d, b);
        #1;
        chk("seg", {20'd0, seg}, {20'd0, m_seg});
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    endtask

    task automatic idle_until(input int c);
        while (m_cyc < c) step(1'b1, 1'b0, $urandom, 1'b0);
    endtask

    logic        acc;
    logic [31:0] fa, fb, fc, fd;

    initial begin
        rst_n = 1'b0; frm_valid = 1'b0; frm_data = '0; blank = 1'b0;

        // Reset and idle scan with no frames.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_seg", {20'd0, seg}, 32'hFFF);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, $urandom, 1'b0);
            if (k == 3)  chk("idle_blank", {20'd0, seg}, 32'hFFF);
            if (k == 4)  chk("idle_d0", {20'd0, seg}, 32'hEFF);
            if (k == 8)  chk("idle_d1", {20'd0, seg}, 32'hDFF);
            if (k == 12) chk("idle_d2", {20'd0, seg}, 32'hBFF);
            if (k == 16) chk("idle_d3", {20'd0, seg}, 32'h7FF);
            if (k == 16) chk("idle_fd", {31'd0, frame_done}, 32'd1);
        end

        // Frame sent during digit 1 appears after the next boundary.
        idle_until(20);
        step(1'b1, 1'b1, 32'hB0A4_F9C0, 1'b0);
        #1;
        chk("rdy_drop", {31'd0, frm_ready}, 32'd0);
        idle_until(32);
        chk("swap_fd", {31'd0, frame_done}, 32'd1);
        chk("rdy_back", {31'd0, frm_ready}, 32'd1);
        idle_until(36); chk("new_d0", {20'd0, seg}, 32'hEC0);
        idle_until(40); chk("new_d1", {20'd0, seg}, 32'hDF9);
        idle_until(44); chk("new_d2", {20'd0, seg}, 32'hBA4);
        idle_until(48); chk("new_d3", {20'd0, seg}, 32'h7B0);

        // Back-to-back frames with valid held: second stalls until first swaps.
        fa = $urandom; fb = $urandom;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin step(1'b1, 1'b1, fa, 1'b0); acc = m_xfer; end
        chk("a_accepted", {31'd0, acc}, 32'd1);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin step(1'b1, 1'b1, fb, 1'b0); acc = m_xfer; end
        chk("b_accepted", {31'd0, acc}, 32'd1);
        idle_until(m_cyc + 40);

        // Transfer exactly in a boundary cycle.
        for (int i = 0; i < 64 && !((m_cyc % 16) == 15 && !m_full); i++) step(1'b1, 1'b0, $urandom, 1'b0);
        fc = $urandom;
        step(1'b1, 1'b1, fc, 1'b0);
        chk("bnd_accepted", {31'd0, m_xfer}, 32'd1);
        idle_until(m_cyc + 36);

        // Blank during digits 1 and 2 of one frame.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, $urandom, (((m_cyc / TD) % 4) == 1) || (((m_cyc / TD) % 4) == 2));

        // One-cycle reset while digit 2 is scanning and a frame is pending.
        idle_until(((m_cyc + 15) / 16) * 16);
        fd = $urandom;
        step(1'b1, 1'b1, fd, 1'b0);
        chk("pend_accepted", {31'd0, m_xfer}, 32'd1);
        idle_until(((m_cyc / 16) * 16) + 8);
        step(1'b0, 1'b0, $urandom, 1'b0);
        chk("mid_rst_seg", {20'd0, seg}, 32'hFFF);
        chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        idle_until(40);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 7) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
